// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch port.
package imem_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } imem_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Parity helper takes a fixed-width operand; callers zero-extend their data.
   localparam int IMEM_PAR_MAX_W = 64;

   function automatic logic imem_parity(input logic [IMEM_PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port instruction RAM: synchronous write, registered read gated by re.
module imem_array
   import imem_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];
   logic [WIDTH-1:0] rdata_q;

   // Contents are deliberately not reset; the loader owns initialisation.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with loader port and handshaked, registered fetch port.
// Optional even-parity protection of the array: define IMEM_PARITY_EN.
//
// state | meaning
// BOOT  | loader writes the array, fetch port held not-ready
// RUN   | fetches served, loader writes ignored (only rst_n leaves RUN)
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [PC_W-1:0]   req_pc,
   input  logic              flush,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [PC_W-1:0]   rsp_pc,
   output logic              rsp_err,
   output logic              boot_mode
);

`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   imem_state_e       state_q, state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
   logic              addr_err_q, addr_err_d;
   logic              data_ok_q, data_ok_d;

   logic              accept;
   logic              fetch_err;
   logic              par_err;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  mem_rdata;

   assign fetch_err = (req_pc[1:0] != 2'b00) || (req_pc[PC_W-1:ADDR_W+2] != '0);
   assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready || flush);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      if (state_q == BOOT && ld_done) state_d = RUN;
   end

   // A new accept always wins over flush or consumption of the held response.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_pc_d    = rsp_pc_q;
      addr_err_d  = addr_err_q;
      data_ok_d   = data_ok_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_pc_d    = req_pc;
         addr_err_d  = fetch_err;
         data_ok_d   = !fetch_err;
      end else if (flush || rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
         addr_err_q  <= 1'b0;
         data_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_pc_q    <= rsp_pc_d;
         addr_err_q  <= addr_err_d;
         data_ok_q   <= data_ok_d;
      end
   end

   assign mem_we   = (state_q == BOOT) && ld_we;
   assign mem_re   = accept && !fetch_err;
   assign mem_addr = (state_q == BOOT) ? ld_addr : req_pc[ADDR_W+1:2];

`ifdef IMEM_PARITY_EN
   assign mem_wdata = {imem_parity(IMEM_PAR_MAX_W'(ld_data)), ld_data};
   assign par_err   = data_ok_q &&
                      (imem_parity(IMEM_PAR_MAX_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`else
   assign mem_wdata = ld_data;
   assign par_err   = 1'b0;
`endif

   imem_array #(
      .ADDR_W (ADDR_W),
      .WIDTH  (MEM_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // The read register is never reset, so data is exposed only after an in-range read.
   assign rsp_instr = data_ok_q ? mem_rdata[DATA_W-1:0] : DATA_W'(NOP_INSTR);
   assign rsp_err   = addr_err_q || par_err;
   assign rsp_valid = rsp_valid_q;
   assign rsp_pc    = rsp_pc_q;
   assign boot_mode = (state_q == BOOT);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: directed table, corner sequences, random vs model.
module tb_imem_fetch_port;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;
   localparam int DEPTH  = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_done;
   logic              req_valid;
   logic              req_ready;
   logic [PC_W-1:0]   req_pc;
   logic              flush;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [PC_W-1:0]   rsp_pc;
   logic              rsp_err;
   logic              boot_mode;

   always #5 clk = ~clk;

   imem_fetch_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_done   (ld_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_pc    (req_pc),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_pc    (rsp_pc),
      .rsp_err   (rsp_err),
      .boot_mode (boot_mode)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] model_mem [DEPTH];

   typedef struct {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] instr;
      logic              err;
   } rsp_t;

   typedef struct {
      logic [PC_W-1:0]   pc;
      logic              exp_err;
      logic [DATA_W-1:0] exp_instr;
   } vec_t;

   vec_t vecs [8];
   rsp_t pend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic rsp_t model_fetch(input logic [PC_W-1:0] pc);
      rsp_t r;
      r.valid = 1'b1;
      r.pc    = pc;
      r.err   = (pc % 4 != 0) || (pc >= 4 * DEPTH);
      r.instr = r.err ? '0 : model_mem[pc / 4];
      return r;
   endfunction

   task automatic fetch_one(input string name, input logic [PC_W-1:0] pc,
                            input logic exp_err, input logic [DATA_W-1:0] exp_instr);
      req_valid = 1'b1;
      req_pc    = pc;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({name, ".req_ready"}, 64'(req_ready), 64'(1));
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk({name, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
      chk({name, ".rsp_pc"}, 64'(rsp_pc), 64'(pc));
      chk({name, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
      chk({name, ".rsp_instr"}, 64'(rsp_instr), 64'(exp_instr));
      step();
   endtask

   initial begin
      rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
      req_valid = 1'b1; req_pc = '0; flush = 1'b0; rsp_ready = 1'b1;

      // reset and BOOT behaviour
      repeat (2) @(negedge clk);
      chk("reset.boot_mode", 64'(boot_mode), 64'(1));
      chk("reset.req_ready", 64'(req_ready), 64'(0));
      chk("reset.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset.rsp_instr", 64'(rsp_instr), 64'(0));
      chk("reset.rsp_pc", 64'(rsp_pc), 64'(0));
      chk("reset.rsp_err", 64'(rsp_err), 64'(0));
      rst_n = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("boot.req_ready", 64'(req_ready), 64'(0));
      chk("boot.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("boot.boot_mode", 64'(boot_mode), 64'(1));
      step();
      req_valid = 1'b0;

      // load; the last write coincides with ld_done
      for (int i = 0; i < DEPTH; i++) begin
         ld_we   = 1'b1;
         ld_addr = ADDR_W'(i);
         ld_data = (i < 4) ? 32'h2008_0001 + 32'(i) : (i == DEPTH - 1) ? 32'hDEAD_BEEF : $urandom;
         ld_done = (i == DEPTH - 1);
         model_mem[i] = ld_data;
         step();
      end
      ld_we = 1'b0; ld_done = 1'b0;
      @(negedge clk);
      chk("run.boot_mode", 64'(boot_mode), 64'(0));
      chk("run.req_ready_idle", 64'(req_ready), 64'(1));
      step();

      // back-to-back, 1-cycle latency
      rsp_ready = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            req_valid = 1'b1;
            req_pc    = PC_W'(4 * k);
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         if (k > 0) begin
            chk("b2b.rsp_valid", 64'(rsp_valid), 64'(1));
            chk("b2b.rsp_pc", 64'(rsp_pc), 64'(4 * (k - 1)));
            chk("b2b.rsp_instr", 64'(rsp_instr), 64'(32'h2008_0001 + 32'(k - 1)));
         end
         if (k < 4) chk("b2b.req_ready", 64'(req_ready), 64'(1));
         step();
      end
      @(negedge clk);
      chk("b2b.drained", 64'(rsp_valid), 64'(0));
      step();

      // backpressure holds the response stable
      req_valid = 1'b1; req_pc = 32'h8;
      step();
      req_pc = 32'hC; rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp.rsp_valid", 64'(rsp_valid), 64'(1));
         chk("bp.rsp_pc", 64'(rsp_pc), 64'(8));
         chk("bp.rsp_instr", 64'(rsp_instr), 64'(32'h2008_0003));
         chk("bp.req_ready", 64'(req_ready), 64'(0));
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp.release_ready", 64'(req_ready), 64'(1));
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp.next_pc", 64'(rsp_pc), 64'(12));
      chk("bp.next_instr", 64'(rsp_instr), 64'(32'h2008_0004));
      step();

      // flush together with a new accept, then flush alone
      req_valid = 1'b1; req_pc = 32'h0; rsp_ready = 1'b0;
      step();
      req_pc = 32'h4; flush = 1'b1;
      @(negedge clk);
      chk("flush_acc.req_ready", 64'(req_ready), 64'(1));
      step();
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("flush_acc.rsp_valid", 64'(rsp_valid), 64'(1));
      chk("flush_acc.rsp_pc", 64'(rsp_pc), 64'(4));
      chk("flush_acc.rsp_instr", 64'(rsp_instr), 64'(32'h2008_0002));
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_only.rsp_valid", 64'(rsp_valid), 64'(0));
      step();

      // loader writes are ignored in RUN
      ld_we = 1'b1; ld_addr = 6'd2; ld_data = 32'hFFFF_FFFF;
      step();
      ld_we = 1'b0;
      fetch_one("run_we_ignored", 32'h8, 1'b0, 32'h2008_0003);

      // directed table
      vecs[0] = '{pc: 32'h0,         exp_err: 1'b0, exp_instr: 32'h2008_0001};
      vecs[1] = '{pc: 32'hC,         exp_err: 1'b0, exp_instr: 32'h2008_0004};
      vecs[2] = '{pc: 32'h6,         exp_err: 1'b1, exp_instr: 32'h0};
      vecs[3] = '{pc: 32'h100,       exp_err: 1'b1, exp_instr: 32'h0};
      vecs[4] = '{pc: 32'hFC,        exp_err: 1'b0, exp_instr: 32'hDEAD_BEEF};
      vecs[5] = '{pc: 32'h1,         exp_err: 1'b1, exp_instr: 32'h0};
      vecs[6] = '{pc: 32'h8000_0004, exp_err: 1'b1, exp_instr: 32'h0};
      vecs[7] = '{pc: 32'h10,        exp_err: 1'b0, exp_instr: model_mem[4]};
      for (int i = 0; i < 8; i++) begin
         fetch_one($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_err, vecs[i].exp_instr);
      end

      // randomized traffic against the transaction-level model
      pend = '{valid: 1'b0, pc: '0, instr: '0, err: 1'b0};
      for (int c = 0; c < 400; c++) begin
         logic exp_ready;
         int   r;
         chk("rnd.rsp_valid", 64'(rsp_valid), 64'(pend.valid));
         if (pend.valid) begin
            chk("rnd.rsp_pc", 64'(rsp_pc), 64'(pend.pc));
            chk("rnd.rsp_instr", 64'(rsp_instr), 64'(pend.instr));
            chk("rnd.rsp_err", 64'(rsp_err), 64'(pend.err));
         end
         req_valid = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 7) == 0);
         ld_we     = ($urandom_range(0, 7) == 0);
         ld_addr   = ADDR_W'($urandom);
         ld_data   = $urandom;
         r = $urandom_range(0, 9);
         if (r < 7)       req_pc = PC_W'($urandom_range(0, DEPTH - 1) * 4);
         else if (r == 7) req_pc = PC_W'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else if (r == 8) req_pc = $urandom | 32'h0000_0100;
         else             req_pc = $urandom;
         #1;
         exp_ready = !pend.valid || rsp_ready || flush;
         chk("rnd.req_ready", 64'(req_ready), 64'(exp_ready));
         if (req_valid && exp_ready) pend = model_fetch(req_pc);
         else if (flush || rsp_ready) pend.valid = 1'b0;
         step();
      end
      req_valid = 1'b0; flush = 1'b0; ld_we = 1'b0; rsp_ready = 1'b1;
      step();

`ifdef IMEM_PARITY_EN
      u_dut.u_array.mem[1] = u_dut.u_array.mem[1] ^ 33'h1;
      fetch_one("parity_flip", 32'h4, 1'b1, model_mem[1] ^ 32'h1);
      fetch_one("parity_clean", 32'h8, 1'b0, 32'h2008_0003);
`endif

      // async reset discards an in-flight response immediately
      req_valid = 1'b1; req_pc = 32'h0; rsp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      chk("arst.pre_valid", 64'(rsp_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("arst.boot_mode", 64'(boot_mode), 64'(1));
      chk("arst.req_ready", 64'(req_ready), 64'(0));
      chk("arst.rsp_pc", 64'(rsp_pc), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
